// File: rtl/noc_pkg.sv
// noc_pkg: router-wide port count, port index encoding and allocator reset values
package noc_pkg;
   localparam int NPORTS = 5;
   localparam int PW = 3;
   localparam logic [PW-1:0] P_LOCAL = 3'd0;
   localparam logic [PW-1:0] P_N = 3'd1;
   localparam logic [PW-1:0] P_E = 3'd2;
   localparam logic [PW-1:0] P_S = 3'd3;
   localparam logic [PW-1:0] P_W = 3'd4;
   localparam logic RST_LOCKED = 1'b0;
   localparam logic [PW-1:0] RST_OWNER = '0;
   localparam logic [PW-1:0] RST_PTR = '0;
endpackage

// File: rtl/rr_out_arb.sv
// rr_out_arb: one output's wormhole lock plus rotating-priority arbiter, zero-cycle grant
module rr_out_arb import noc_pkg::*; #(
   parameter int N = NPORTS,
   parameter int W = PW
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] elig,
   input  logic [N-1:0] tail,
   input  logic         ready,
   output logic [N-1:0] gnt_vec,
   output logic         valid,
   output logic [W-1:0] sel
);
   logic         locked_q, locked_d;
   logic [W-1:0] owner_q, owner_d, ptr_q, ptr_d;
   logic [W-1:0] win, cand, idx;
   logic         found, hit, xfer;
   always_comb begin
      win = '0;
      found = 1'b0;
      idx = '0;
      // scanning from the far end lets the input closest to ptr overwrite last
      for (int k = N - 1; k >= 0; k--) begin
         idx = W'((int'(ptr_q) + k) % N);
         if (elig[idx]) begin
            win = idx;
            found = 1'b1;
         end
      end
      cand = locked_q ? owner_q : win;
      hit = locked_q ? elig[owner_q] : found;
      xfer = reset && hit && ready;
      valid = xfer;
      gnt_vec = xfer ? N'(1) << cand : '0;
      sel = !reset ? '0 : (xfer || locked_q) ? cand : '0;
      locked_d = !reset ? RST_LOCKED : xfer ? !tail[cand] : locked_q;
      owner_d = !reset ? RST_OWNER : (xfer && !tail[cand]) ? cand : owner_q;
      ptr_d = !reset ? RST_PTR : (xfer && tail[cand]) ? W'((int'(cand) + 1) % N) : ptr_q;
   end
   always_ff @(posedge clk) begin
      locked_q <= locked_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
   end
endmodule

// File: rtl/switch_alloc.sv
// switch_alloc: per-output round-robin wormhole allocator driving buffer pops and crossbar selects
module switch_alloc #(
   parameter int NPORTS = noc_pkg::NPORTS,
   parameter int PW = noc_pkg::PW
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NPORTS-1:0]        req,
   input  logic [NPORTS*NPORTS-1:0] req_port,
   input  logic [NPORTS-1:0]        tail,
   input  logic [NPORTS-1:0]        out_ready,
   output logic [NPORTS-1:0]        gnt,
   output logic [NPORTS-1:0]        out_valid,
   output logic [NPORTS*PW-1:0]     xbar_sel,
   output logic [NPORTS-1:0]        err
);
   logic [NPORTS-1:0] one_hot;
   logic [NPORTS-1:0] elig [NPORTS];
   logic [NPORTS-1:0] og [NPORTS];
   always_comb begin
      one_hot = '0;
      err = '0;
      for (int i = 0; i < NPORTS; i++) begin
         one_hot[i] = $onehot(req_port[i*NPORTS +: NPORTS]);
         err[i] = reset && req[i] && !one_hot[i];
      end
      for (int o = 0; o < NPORTS; o++) begin
         elig[o] = '0;
         for (int i = 0; i < NPORTS; i++)
            elig[o][i] = req[i] && one_hot[i] && req_port[i*NPORTS + o];
      end
   end
   always_comb begin
      gnt = '0;
      for (int o = 0; o < NPORTS; o++) gnt = gnt | og[o];
   end
   for (genvar o = 0; o < NPORTS; o++) begin : g_out
      rr_out_arb #(.N(NPORTS), .W(PW)) u_arb (
         .clk     (clk),
         .reset   (reset),
         .elig    (elig[o]),
         .tail    (tail),
         .ready   (out_ready[o]),
         .gnt_vec (og[o]),
         .valid   (out_valid[o]),
         .sel     (xbar_sel[o*PW +: PW])
      );
   end
endmodule

// File: doc/switch_alloc.md
# switch_alloc

Per-output round-robin switch allocator for the 5-port mesh XY router. Each input port's route-computation stage delivers a one-hot output-port request (e1..e5 order). This block arbitrates those requests per output port and locks each output to one input from head flit to tail flit (wormhole). It drives the input-buffer pop strobes and the crossbar select lines, and sits between the per-input route computation and the 5×5 crossbar.

## Interface
Parameters:
- NPORTS, 5, number of router ports (local, N, E, S, W; index = route port number 0..4)
- PW, 3, width of a port index (clog2 NPORTS)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-low: reset==0 at a rising edge clears all state
- req  in  NPORTS  input i has a flit at its buffer head
- req_port  in  NPORTS*NPORTS  bits [i*NPORTS +: NPORTS] are the one-hot requested output of input i (bit0=e1 … bit4=e5)
- tail  in  NPORTS  flit at input i is a tail flit (single-flit packets have tail=1)
- out_ready  in  NPORTS  downstream of output o can accept a flit this cycle (credit available)
- gnt  out  NPORTS  input i's head flit transfers this cycle; the buffer pops on this
- out_valid  out  NPORTS  output o carries a flit this cycle
- xbar_sel  out  NPORTS*PW  bits [o*PW +: PW] are the input index driving output o
- err  out  NPORTS  input i has req=1 with req_port not one-hot (zero or multi-bit)

## Operation
- Per output o, registered state: locked_o (1b), owner_o (PW), ptr_o (PW, round-robin start).
- Request vector for output o: input i is eligible iff req[i] && req_port[i][o] && req_port[i] is one-hot. A non-one-hot request is never eligible and raises err[i] combinationally.
- locked_o=1: the only candidate is owner_o. A transfer occurs iff owner is eligible && out_ready[o]. Other inputs are ignored.
- locked_o=0: the winner is the first eligible input scanning ptr_o, ptr_o+1, … mod NPORTS. A transfer occurs iff a winner exists && out_ready[o].
- On a transfer w→o: gnt[w]=1, out_valid[o]=1, xbar_sel[o]=w.
- With no transfer: out_valid[o]=0, xbar_sel[o]=owner_o when locked, else 0.
- State update at edge, on a transfer:
  - tail[w]=0: locked_o←1, owner_o←w.
  - tail[w]=1: locked_o←0, ptr_o←(w+1) mod NPORTS (wrap 4→0).
- No transfer: state is held. A lock survives out_ready=0 and req=0 bubbles indefinitely.
- Each input requests exactly one output, so gnt never conflicts. Different outputs grant in parallel in the same cycle.
- Reset (reset==0 at an edge): locked_o←0, owner_o←0, ptr_o←0 for all o.
  - While reset==0, force gnt=0, out_valid=0, xbar_sel=0, err=0.
  - Reset mid-packet drops the lock. Upstream buffers are flushed by their own reset.

## Timing
- gnt, out_valid, xbar_sel and err are combinational from the current inputs plus registered state: zero-cycle grant.
- Lock/pointer changes take effect in the cycle after the transferring edge.
- Input holds req/req_port/tail stable until gnt. The next flit may appear the following cycle.
- Worst-case head-flit wait with all 5 inputs contending single-flit traffic: 4 cycles.

## Structure
- Shared package noc_pkg: NPORTS, PW, port index constants (P_LOCAL=0 … P_W=4) matching the routing-table encoding, and the reset-value constants.
- One sub-module rr_out_arb holds locked/owner/ptr, the rotate-priority scan and grant for a single output. It is instantiated NPORTS times.
- The top level transposes req_port into per-output request vectors, ORs per-output grants into gnt, and computes err.

## Test plan
- Reset: reset=0, req=5'b11111, all requests to output 0, out_ready all 1 → gnt=0, out_valid=0, xbar_sel=0. After release, the first cycle grants input 0.
- Single flit: input 2 requests output 2 (req_port slice 5'b00100), tail=1, out_ready=1 → same cycle gnt=5'b00100, out_valid[2]=1, xbar_sel[2]=2. Next cycle ptr_2=3.
- Round-robin: inputs 0, 1, 3 hold single-flit requests to output 4 from ptr_4=0 → grants 0, 1, 3, 0 on consecutive cycles.
- Wormhole lock: input 1 sends a 3-flit packet to output 0 while input 4 also requests output 0 → input 1 is granted 3 consecutive cycles, then input 4 is granted the next cycle.
- Backpressure and reset mid-packet:
  - out_ready[0]=0 for 2 cycles after input 1's head → no gnt, lock held. Input 1 resumes when ready returns.
  - reset=0 mid-packet → next cycle after release, input 4 can win output 0.
- Parallel/error: input 0→output 3 and input 2→output 1 in the same cycle → both granted. Input 3 with req_port slice 5'b00110 → err[3]=1, never granted.
